main_memory_responder: RTL and testbench

Backing-store responder on the memory side of `cache_controller`. It accepts block-granular line-fill and write-back requests from the cache miss path. After a fixed access latency it services each one as a burst of byte beats, then signals completion. It serves as the main-memory model in cache simulations and as the synthesizable template for the real memory port.

---
 rtl/main_memory_responder_pkg.sv | 21 ++
 rtl/main_memory_responder_if.sv | 39 +++
 rtl/main_memory_responder_mem_byte_array.sv | 29 ++
 rtl/main_memory_responder.sv | 139 +++++++++++++
 tb/tb_main_memory_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/main_memory_responder_pkg.sv
`default_nettype none
// ==== cache_pkg : opcode encoding, line geometry and responder state encoding ==== rev 1.0

package cache_pkg;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int BLOCK_BYTES = 16;
   localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } resp_state_e;

endpackage

`default_nettype wire

// File: rtl/main_memory_responder_if.sv
`default_nettype none
// ==== main_memory_responder_if : cache-to-memory request/beat bus ==== rev 1.0

interface main_memory_responder_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wready;
   logic [7:0]  mem_rdata;
   logic        mem_rvalid;
   logic        mem_done;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_wready,
      input  mem_rdata,
      input  mem_rvalid,
      input  mem_done
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_wready,
      output mem_rdata,
      output mem_rvalid,
      output mem_done
   );

endinterface

`default_nettype wire

// File: rtl/main_memory_responder_mem_byte_array.sv
`default_nettype none
// ==== mem_byte_array : single-port byte RAM, synchronous write, asynchronous read ==== rev 1.0

module mem_byte_array #(
   parameter int MEM_DEPTH_LOG2 = 10
) (
   input  wire logic                      clk,
   input  wire logic                      i_we,
   input  wire logic [MEM_DEPTH_LOG2-1:0] i_addr,
   input  wire logic [7:0]                i_wdata,
   output logic      [7:0]                o_rdata
);

   localparam int c_DEPTH = 1 << MEM_DEPTH_LOG2;

   // Contents survive reset, so the array has no reset branch at all.
   logic [7:0] r_mem [c_DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ==== main_memory_responder : fixed-latency line-fill / write-back byte-burst responder ==== rev 1.0

module main_memory_responder
   import cache_pkg::*;
#(
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int BLOCK_BYTES    = cache_pkg::BLOCK_BYTES,
   parameter int LATENCY        = 4
) (
   input  wire logic               clk,
   input  wire logic               rst_b,
   main_memory_responder_if.slave  bus,
   output logic                    busy
);

   localparam int c_OFF_BITS = $clog2(BLOCK_BYTES);
   localparam int c_LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [MEM_DEPTH_LOG2-1:0] c_OFF_MASK  = MEM_DEPTH_LOG2'(BLOCK_BYTES - 1);
   localparam logic [c_OFF_BITS-1:0]     c_LAST_BEAT = c_OFF_BITS'(BLOCK_BYTES - 1);
   localparam logic [c_LAT_W-1:0]        c_LAT_LOAD  = c_LAT_W'(LATENCY - 1);

   resp_state_e               r_state;
   resp_state_e               w_state_nxt;
   logic [c_LAT_W-1:0]        r_lat_cnt;
   logic [c_OFF_BITS-1:0]     r_beat;
   logic [MEM_DEPTH_LOG2-1:0] r_base;
   logic                      r_we;

   logic                      w_busy;
   logic                      w_rvalid;
   logic                      w_wready;
   logic                      w_done;
   logic [MEM_DEPTH_LOG2-1:0] w_beat_addr;
   logic [7:0]                w_rd_byte;
   logic                      w_unused_addr;

   // Address bits above the storage size alias and are deliberately dropped.
   assign w_unused_addr = ^bus.mem_addr[31:MEM_DEPTH_LOG2];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_rvalid    = 1'b0;
      w_wready    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.mem_req) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_lat_cnt == '0) begin
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            w_rvalid = (r_we == OP_READ);
            w_wready = (r_we == OP_WRITE);
            if (r_beat == c_LAST_BEAT) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_busy      = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request fields are frozen at accept; the beat index wraps inside the line.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_lat_cnt <= '0;
         r_beat    <= '0;
         r_base    <= '0;
         r_we      <= OP_READ;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.mem_req) begin
                  r_base    <= bus.mem_addr[MEM_DEPTH_LOG2-1:0] & ~c_OFF_MASK;
                  r_we      <= bus.mem_we;
                  r_lat_cnt <= c_LAT_LOAD;
               end
            end
            ST_WAIT: begin
               if (r_lat_cnt == '0) begin
                  r_beat <= '0;
               end else begin
                  r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
               end
            end
            ST_XFER: begin
               r_beat <= r_beat + c_OFF_BITS'(1);
            end
            default: begin
               r_beat <= r_beat;
            end
         endcase
      end
   end

   assign w_beat_addr = r_base | MEM_DEPTH_LOG2'(r_beat);

   mem_byte_array #(
      .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .i_we    (w_wready),
      .i_addr  (w_beat_addr),
      .i_wdata (bus.mem_wdata),
      .o_rdata (w_rd_byte)
   );

   assign busy           = w_busy;
   assign bus.mem_rvalid = w_rvalid;
   assign bus.mem_wready = w_wready;
   assign bus.mem_done   = w_done;
   assign bus.mem_rdata  = w_rvalid ? w_rd_byte : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ==== tb_main_memory_responder : randomized scoreboard bench with byte-array reference model ==== rev 1.0

module tb_main_memory_responder;

   localparam int DEPTH_LOG2 = 10;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int BB         = 16;
   localparam int LAT        = 4;
   localparam int TIMEOUT    = 200;

   typedef struct packed {
      logic            we;
      logic            abort;
      logic [31:0]     acc;
      logic [BB*8-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_b = 1'b1;
   logic busy;

   main_memory_responder_if bus();

   main_memory_responder #(
      .MEM_DEPTH_LOG2 (DEPTH_LOG2),
      .BLOCK_BYTES    (BB),
      .LATENCY        (LAT)
   ) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   logic [7:0]      model [DEPTH];
   exp_t            sb [$];
   logic [BB*8-1:0] cur_wbuf;

   exp_t cur;
   bit   have_cur = 1'b0;
   int   mbeat    = 0;

   always @(negedge clk) begin
      if (rst_b === 1'b1) begin
         if (bus.mem_rvalid || bus.mem_wready) begin
            if (!have_cur) begin
               if (sb.size() == 0) begin
                  chk("unexpected_beat", 32'({bus.mem_wready, bus.mem_rvalid}), 0);
               end else begin
                  cur      = sb.pop_front();
                  have_cur = 1'b1;
                  mbeat    = 0;
               end
            end
            if (have_cur) begin
               chk("beat_kind", 32'({bus.mem_wready, bus.mem_rvalid}), cur.we ? 32'd2 : 32'd1);
               chk("beat_cycle", cyc, cur.acc + 32'(1 + LAT + mbeat));
               if (!cur.we) begin
                  chk("fill_rdata", 32'(bus.mem_rdata), 32'(cur.data[mbeat*8 +: 8]));
               end
               mbeat++;
               if (cur.abort && mbeat == 3) begin
                  have_cur = 1'b0;
               end
            end
         end
         if (bus.mem_done) begin
            if (!have_cur) begin
               chk("unexpected_done", 32'(bus.mem_done), 0);
            end else begin
               chk("done_beat_count", mbeat, BB);
               chk("done_cycle", cyc, cur.acc + 32'(1 + LAT + BB));
               have_cur = 1'b0;
            end
         end
      end
   end

   // Called at a falling edge with the responder idle; the next rising edge accepts.
   task automatic start_txn(input logic we, input logic [31:0] addr,
                            input logic [BB*8-1:0] wbuf, input logic abort);
      exp_t e;
      int   base;
      chk("idle_at_issue", 32'(busy), 0);
      base    = (int'(addr % DEPTH) / BB) * BB;
      e.we    = we;
      e.abort = abort;
      e.acc   = cyc;
      e.data  = '0;
      for (int b = 0; b < BB; b++) begin
         if (we) begin
            if (!abort || b < 3) model[base + b] = wbuf[b*8 +: 8];
         end else begin
            e.data[b*8 +: 8] = model[base + b];
         end
      end
      sb.push_back(e);
      cur_wbuf      = wbuf;
      bus.mem_req   = 1'b1;
      bus.mem_we    = we;
      bus.mem_addr  = addr;
      bus.mem_wdata = wbuf[7:0];
   endtask

   task automatic finish_txn(input logic hold, input logic abort);
      logic consumed;
      logic seen;
      int   wb;
      consumed = 1'b0;
      seen     = 1'b0;
      wb       = 0;
      for (int k = 0; k < TIMEOUT && !seen; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            bus.mem_addr = $urandom;
            bus.mem_we   = 1'($urandom);
         end
         if (consumed) begin
            wb++;
            bus.mem_wdata = (wb < BB) ? cur_wbuf[wb*8 +: 8] : 8'($urandom);
         end
         @(negedge clk);
         if (k == 0) chk("busy_after_accept", 32'(busy), 1);
         consumed = bus.mem_wready;
         if (abort && consumed && wb == 2) begin
            @(posedge clk);
            #1;
            rst_b       = 1'b0;
            bus.mem_req = 1'b0;
            #1;
            chk("abort_outputs_cleared",
                32'({busy, bus.mem_rvalid, bus.mem_wready, bus.mem_done, bus.mem_rdata}), 0);
            repeat (3) begin
               @(negedge clk);
               chk("abort_held_idle", 32'({busy, bus.mem_done}), 0);
            end
            rst_b = 1'b1;
            seen  = 1'b1;
         end else if (bus.mem_done) begin
            seen = 1'b1;
            chk("busy_in_done", 32'(busy), 1);
            if (!hold) bus.mem_req = 1'b0;
         end
      end
      chk("txn_completed", 32'(seen), 1);
   endtask

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [BB*8-1:0] wbuf);
      start_txn(we, addr, wbuf, 1'b0);
      finish_txn(1'b0, 1'b0);
      @(negedge clk);
   endtask

   function automatic logic [BB*8-1:0] rand_buf();
      logic [BB*8-1:0] v;
      for (int i = 0; i < BB / 4; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      logic [BB*8-1:0] wbuf;
      logic            hold;

      for (int i = 0; i < DEPTH; i++) begin
         model[i]             = 8'(i);
         dut.u_array.r_mem[i] <= 8'(i);
      end

      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0000_0010;
      bus.mem_wdata = 8'h00;
      #2;
      rst_b = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("reset_outputs",
             32'({busy, bus.mem_rvalid, bus.mem_wready, bus.mem_done, bus.mem_rdata}), 0);
      end
      rst_b = 1'b1;
      start_txn(1'b0, 32'h0000_0010, '0, 1'b0);
      finish_txn(1'b0, 1'b0);
      @(negedge clk);

      for (int b = 0; b < BB; b++) wbuf[b*8 +: 8] = 8'(8'hA5 + b);
      do_txn(1'b1, 32'h0000_0080, wbuf);
      do_txn(1'b0, 32'h0000_0080, '0);
      do_txn(1'b0, 32'h0000_0085, '0);
      do_txn(1'b0, 32'h0000_0410, '0);

      start_txn(1'b0, 32'h0000_0020, '0, 1'b0);
      finish_txn(1'b1, 1'b0);
      @(negedge clk);
      start_txn(1'b1, 32'h0000_0030, rand_buf(), 1'b0);
      finish_txn(1'b0, 1'b0);
      @(negedge clk);
      do_txn(1'b0, 32'h0000_0030, '0);

      start_txn(1'b1, 32'h0000_0200, rand_buf(), 1'b1);
      finish_txn(1'b0, 1'b1);
      @(negedge clk);
      do_txn(1'b0, 32'h0000_0200, '0);

      for (int t = 0; t < 24; t++) begin
         hold = (t != 23) && ($urandom_range(3) == 0);
         start_txn(1'($urandom), $urandom, rand_buf(), 1'b0);
         finish_txn(hold, 1'b0);
         @(negedge clk);
      end

      bus.mem_req = 1'b0;
      repeat (30) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()) + 32'(have_cur), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
